bcd_count_ctrl: RTL and testbench
=================================

# bcd_count_ctrl

Sequencing controller for the two-digit BCD counter datapath on the DE1 board. It debounces the run/pause and clear pushbuttons and generates the 1 Hz count-enable from CLOCK_50. It also issues clear and preset-load strobes, and enforces stop-at-99 or wrap behaviour. The datapath holds the digits and drives HEX0/HEX1; this block only sequences it through one-cycle strobes.

## Interface

- DIV, 50000000: CLOCK_50 cycles per count tick (1 Hz at 50 MHz); must be ≥ 2.
- DEB_CYCLES, 500000: stable cycles required to accept a button level (10 ms); must be ≥ 1.

- CLOCK_50 in 1: system clock; all logic on posedge.
- KEY in 1: KEY[0], asynchronous active-low reset.
- btn_run_n in 1: active-low pushbutton, toggles run/pause; asynchronous to clock.
- btn_clr_n in 1: active-low pushbutton, clear; asynchronous to clock.
- sw_load in 1: slide switch; a rising edge requests a preset load; asynchronous.
- sw_preset in 8: preset value, [7:4] tens BCD, [3:0] units BCD.
- sw_wrap in 1: 1 = wrap 99→00; 0 = stop at 99.
- tc in 1: from datapath, high when count == 99.
- cnt_en out 1: one-cycle pulse, datapath increments by one.
- cnt_clr out 1: one-cycle pulse, datapath goes to 00.
- cnt_load out 1: one-cycle pulse, datapath loads load_val.
- load_val out 8: registered copy of sw_preset captured at load acceptance.
- state out 2: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- preset_err out 1: sticky, set when a load is attempted with a digit > 9.

## Operation

- **Input conditioning**
  - Each of btn_run_n, btn_clr_n and sw_load passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles. Any bounce restarts that count.
  - Events are one-cycle pulses on debounced edges: run_ev on btn_run_n falling, clr_ev on btn_clr_n falling, load_ev on sw_load rising.
- **Prescaler**
  - Counter 0..DIV-1; it advances only in RUN.
  - tick is asserted when prescaler == DIV-1 in RUN; the prescaler then wraps to 0.
  - The prescaler holds its value in PAUSE, so the partial second is preserved.
  - It is forced to 0 on clear, on IDLE→RUN, and in IDLE and DONE.
- **FSM.** Evaluate per cycle in priority order clr_ev > load_ev > run_ev > tick.
  - clr_ev, any state: cnt_clr pulse, state→IDLE, preset_err cleared.
  - load_ev in IDLE or PAUSE:
    - both digits ≤ 9: cnt_load pulse, load_val←sw_preset, state unchanged.
    - otherwise: no strobe, preset_err←1.
  - load_ev in RUN or DONE: ignored.
  - run_ev: IDLE→RUN, RUN→PAUSE, PAUSE→RUN, DONE→IDLE (no clear).
  - tick in RUN:
    - tc=1 and sw_wrap=0: no cnt_en, state→DONE.
    - otherwise: cnt_en pulse. The datapath wraps 99→00.
- At most one strobe among cnt_en, cnt_clr and cnt_load is high in any cycle.
- An event of lower priority that coincides with a higher one is dropped, not queued.

## Timing

- Reset values: state=IDLE, cnt_en=cnt_clr=cnt_load=0, load_val=8'h00, preset_err=0.
- Reset also sets the prescaler to 0, the debounced levels to 1 (btn_run_n, btn_clr_n) and to 0 (sw_load), and the debounce counters to 0.
- Reset takes effect immediately and asynchronously at any point, including mid-tick or mid-debounce. No strobe is emitted on release.
- Button latency: a pin change held stably produces its strobe/state change on the outputs 2 (sync) + DEB_CYCLES + 1 (edge) + 1 (registered output) cycles after first sampling.
- All outputs are registered. Strobes are exactly one CLOCK_50 cycle wide.
- In continuous RUN, cnt_en pulses are exactly DIV cycles apart. The first pulse comes DIV cycles after the IDLE→RUN transition.
- PAUSE→RUN resumes the prescaler: the first cnt_en comes after (DIV − held prescaler value) cycles.
- tc is sampled in the tick cycle only.

## Test plan

Directed scenarios, with DIV=4 and DEB_CYCLES=2:

- Reset, then press run → state 01; cnt_en at 4, 8, 12 cycles after the transition; no other strobes.
- Button bouncing low/high every cycle for 6 cycles, then held low → exactly one run_ev, with no state change before stabilization.
- In RUN, press run at prescaler=2, wait 20 cycles, press run again → state 10, then 01. The next cnt_en comes 2 cycles after re-entering RUN.
- sw_wrap=0, tc=1 at tick → no cnt_en, state 11. Repeat with sw_wrap=1 → cnt_en pulses, state stays 01.
- In PAUSE, raise sw_load with sw_preset=8'h47 → one cnt_load, load_val=8'h47.
  - With sw_preset=8'h4A → no cnt_load, preset_err=1.
  - Then press clear → cnt_clr pulse, preset_err=0, state 00.
- Clear and run events in the same cycle while in RUN → only cnt_clr pulses, state 00. Assert KEY low mid-RUN → all outputs return to reset values immediately.

Source files
------------

// File: rtl/bcd_count_ctrl_if.sv
// Board-side bundle for the BCD count controller: debounced-input pins,
// preset/wrap switches, the datapath terminal count, and the strobes and
// status the controller returns. The controller takes the slave view.
interface bcd_count_ctrl_if;
  logic       btn_run_n;
  logic       btn_clr_n;
  logic       sw_load;
  logic [7:0] sw_preset;
  logic       sw_wrap;
  logic       tc;
  logic       cnt_en;
  logic       cnt_clr;
  logic       cnt_load;
  logic [7:0] load_val;
  logic [1:0] state;
  logic       preset_err;

  modport slave (
    input  btn_run_n, btn_clr_n, sw_load, sw_preset, sw_wrap, tc,
    output cnt_en, cnt_clr, cnt_load, load_val, state, preset_err
  );

  modport master (
    output btn_run_n, btn_clr_n, sw_load, sw_preset, sw_wrap, tc,
    input  cnt_en, cnt_clr, cnt_load, load_val, state, preset_err
  );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for the two-digit BCD counter datapath.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | stopped, prescaler held at 0, presets accepted
//   RUN   | prescaler advancing, cnt_en once per DIV cycles
//   PAUSE | prescaler frozen mid-second, presets accepted
//   DONE  | reached 99 with wrap disabled, waits for run or clear
//
// Button path: 2-flop sync -> debounce -> edge register -> FSM output
// register, so a clean press shows up DEB_CYCLES + 4 cycles later.
module bcd_count_ctrl #(
  parameter int DIV        = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic              CLOCK_50,
  input  logic              KEY,
  bcd_count_ctrl_if.slave   bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // bit order for the conditioned inputs: {sw_load, btn_clr_n, btn_run_n}
  localparam logic [2:0] IN_IDLE = 3'b011;

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [2:0]    r_deb_q;
  logic [DW-1:0] r_deb_cnt [0:2];
  logic          r_run_ev;
  logic          r_clr_ev;
  logic          r_load_ev;
  logic [PW-1:0] r_presc;
  state_t        r_state;
  logic          r_cnt_en;
  logic          r_cnt_clr;
  logic          r_cnt_load;
  logic [7:0]    r_load_val;
  logic          r_preset_err;

  logic          w_tick;
  logic          w_preset_ok;
  state_t        w_state_nxt;
  logic          w_cnt_en_nxt;
  logic          w_cnt_clr_nxt;
  logic          w_cnt_load_nxt;
  logic [7:0]    w_load_val_nxt;
  logic          w_preset_err_nxt;

  // Two-flop synchronizers for the asynchronous buttons and load switch.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_sync1 <= IN_IDLE;
      r_sync2 <= IN_IDLE;
    end else begin
      r_sync1 <= {bus.sw_load, bus.btn_clr_n, bus.btn_run_n};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_deb <= IN_IDLE;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
            r_deb[i]     <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Edge stage: one-cycle events on press (falling) or load-switch rise.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_deb_q   <= IN_IDLE;
      r_run_ev  <= 1'b0;
      r_clr_ev  <= 1'b0;
      r_load_ev <= 1'b0;
    end else begin
      r_deb_q   <= r_deb;
      r_run_ev  <= r_deb_q[0] & ~r_deb[0];
      r_clr_ev  <= r_deb_q[1] & ~r_deb[1];
      r_load_ev <= ~r_deb_q[2] & r_deb[2];
    end
  end

  assign w_tick      = (r_state == S_RUN) && (r_presc == PW'(DIV - 1));
  assign w_preset_ok = (bus.sw_preset[7:4] <= 4'd9) && (bus.sw_preset[3:0] <= 4'd9);

  // Prescaler: advances in RUN, frozen in PAUSE and on the pausing cycle
  // itself so the partial second survives, zero everywhere else.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_presc <= '0;
    end else if (r_clr_ev) begin
      r_presc <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_run_ev)    r_presc <= r_presc;
          else if (w_tick) r_presc <= '0;
          else             r_presc <= r_presc + PW'(1);
        end
        S_PAUSE: r_presc <= r_presc;
        default: r_presc <= '0;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      r_state      <= S_IDLE;
      r_cnt_en     <= 1'b0;
      r_cnt_clr    <= 1'b0;
      r_cnt_load   <= 1'b0;
      r_load_val   <= 8'h00;
      r_preset_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt_en     <= w_cnt_en_nxt;
      r_cnt_clr    <= w_cnt_clr_nxt;
      r_cnt_load   <= w_cnt_load_nxt;
      r_load_val   <= w_load_val_nxt;
      r_preset_err <= w_preset_err_nxt;
    end
  end

  // Next state and strobes; priority clr > load > run > tick, losers dropped.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_en_nxt     = 1'b0;
    w_cnt_clr_nxt    = 1'b0;
    w_cnt_load_nxt   = 1'b0;
    w_load_val_nxt   = r_load_val;
    w_preset_err_nxt = r_preset_err;
    if (r_clr_ev) begin
      w_cnt_clr_nxt    = 1'b1;
      w_state_nxt      = S_IDLE;
      w_preset_err_nxt = 1'b0;
    end else if (r_load_ev && ((r_state == S_IDLE) || (r_state == S_PAUSE))) begin
      if (w_preset_ok) begin
        w_cnt_load_nxt = 1'b1;
        w_load_val_nxt = bus.sw_preset;
      end else begin
        w_preset_err_nxt = 1'b1;
      end
    end else if (r_run_ev) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_PAUSE;
        S_PAUSE: w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_tick) begin
      if (bus.tc && !bus.sw_wrap) w_state_nxt  = S_DONE;
      else                        w_cnt_en_nxt = 1'b1;
    end
  end

  assign bus.cnt_en     = r_cnt_en;
  assign bus.cnt_clr    = r_cnt_clr;
  assign bus.cnt_load   = r_cnt_load;
  assign bus.load_val   = r_load_val;
  assign bus.state      = r_state;
  assign bus.preset_err = r_preset_err;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl with DIV=4, DEB_CYCLES=2.
// A clean press shows up on the outputs 6 cycles after it is driven.
module tb_bcd_count_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 2;

  logic CLOCK_50 = 1'b0;
  logic KEY      = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_en   = 0;
  int   n_clr  = 0;
  int   n_load = 0;
  int   s_en, s_clr, s_load;
  int   found;

  bcd_count_ctrl_if bus();

  bcd_count_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Strobe counters and one-hot strobe check, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (KEY) begin
      n_en   += int'(bus.cnt_en);
      n_clr  += int'(bus.cnt_clr);
      n_load += int'(bus.cnt_load);
      n_chk++;
      assert (((bus.cnt_en & bus.cnt_clr) | (bus.cnt_en & bus.cnt_load) |
               (bus.cnt_clr & bus.cnt_load)) === 1'b0)
      else begin
        n_fail++;
        $error("FAIL strobe_onehot: observed en=%b clr=%b load=%b expected at most one",
               bus.cnt_en, bus.cnt_clr, bus.cnt_load);
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_run(input logic [1:0] exp_state, input string tag);
    bus.btn_run_n = 1'b0;
    steps(6);
    check(tag, 32'(bus.state), 32'(exp_state));
    bus.btn_run_n = 1'b1;
    steps(6);
  endtask

  initial begin
    bus.btn_run_n = 1'b1;
    bus.btn_clr_n = 1'b1;
    bus.sw_load   = 1'b0;
    bus.sw_preset = 8'h00;
    bus.sw_wrap   = 1'b0;
    bus.tc        = 1'b0;
    KEY           = 1'b0;
    steps(3);
    check("rst_state",      32'(bus.state),      32'h0);
    check("rst_cnt_en",     32'(bus.cnt_en),     32'h0);
    check("rst_cnt_clr",    32'(bus.cnt_clr),    32'h0);
    check("rst_cnt_load",   32'(bus.cnt_load),   32'h0);
    check("rst_load_val",   32'(bus.load_val),   32'h0);
    check("rst_preset_err", 32'(bus.preset_err), 32'h0);
    KEY = 1'b1;
    steps(2);

    // bouncing press: no state change until the level is held
    for (int i = 0; i < 6; i++) begin
      bus.btn_run_n = (i % 2 == 1);
      step();
      check("bounce_state", 32'(bus.state), 32'h0);
    end
    bus.btn_run_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("settle_state", 32'(bus.state), 32'h0);
    end
    step();
    check("run_enter", 32'(bus.state), 32'h1);
    bus.btn_run_n = 1'b1;

    // cnt_en at 4, 8, 12 after entering RUN; single run_ev keeps RUN
    for (int c = 1; c <= 12; c++) begin
      step();
      check("run_cnt_en", 32'(bus.cnt_en), 32'(c % 4 == 0));
      check("run_state",  32'(bus.state),  32'h1);
      check("run_other",  32'(bus.cnt_clr | bus.cnt_load), 32'h0);
    end

    // pause with the prescaler at 2
    step();
    bus.btn_run_n = 1'b0;
    steps(3);
    check("pre_pause_en", 32'(bus.cnt_en), 32'h1);
    steps(2);
    check("pre_pause_state", 32'(bus.state), 32'h1);
    step();
    check("pause_state", 32'(bus.state), 32'h2);
    bus.btn_run_n = 1'b1;
    s_en = n_en;
    steps(20);
    check("pause_no_en", 32'(n_en - s_en), 32'h0);
    check("pause_hold",  32'(bus.state),   32'h2);
    bus.btn_run_n = 1'b0;
    steps(6);
    check("resume_state", 32'(bus.state), 32'h1);
    step();
    check("resume_en_early", 32'(bus.cnt_en), 32'h0);
    step();
    check("resume_en", 32'(bus.cnt_en), 32'h1);
    bus.btn_run_n = 1'b1;

    // terminal count with wrap, then without
    bus.tc      = 1'b1;
    bus.sw_wrap = 1'b1;
    steps(3);
    check("wrap_en_early", 32'(bus.cnt_en), 32'h0);
    step();
    check("wrap_en",    32'(bus.cnt_en), 32'h1);
    check("wrap_state", 32'(bus.state),  32'h1);
    bus.sw_wrap = 1'b0;
    steps(3);
    check("stop_pre_state", 32'(bus.state), 32'h1);
    step();
    check("done_state", 32'(bus.state),  32'h3);
    check("done_no_en", 32'(bus.cnt_en), 32'h0);
    bus.tc = 1'b0;

    // load ignored in DONE
    s_en = n_en; s_load = n_load;
    bus.sw_preset = 8'h12;
    bus.sw_load   = 1'b1;
    steps(10);
    check("done_no_load", 32'(n_load - s_load), 32'h0);
    check("done_no_en2",  32'(n_en - s_en),     32'h0);
    check("done_load_val", 32'(bus.load_val),   32'h0);
    check("done_hold",    32'(bus.state),       32'h3);
    bus.sw_load = 1'b0;
    steps(6);

    // DONE -> IDLE without a clear strobe, then into PAUSE
    s_clr = n_clr;
    press_run(2'b00, "done_to_idle");
    check("done_idle_no_clr", 32'(n_clr - s_clr), 32'h0);
    press_run(2'b01, "idle_to_run");
    press_run(2'b10, "run_to_pause");

    // valid preset in PAUSE
    bus.sw_preset = 8'h47;
    bus.sw_load   = 1'b1;
    steps(5);
    check("load_early", 32'(bus.cnt_load), 32'h0);
    step();
    check("load_strobe", 32'(bus.cnt_load), 32'h1);
    check("load_val_47", 32'(bus.load_val), 32'h47);
    step();
    check("load_width", 32'(bus.cnt_load), 32'h0);
    check("load_state", 32'(bus.state),    32'h2);
    bus.sw_load = 1'b0;
    steps(6);

    // invalid units digit
    s_load = n_load;
    bus.sw_preset = 8'h4A;
    bus.sw_load   = 1'b1;
    steps(8);
    check("bad_no_load",  32'(n_load - s_load),  32'h0);
    check("bad_err",      32'(bus.preset_err),   32'h1);
    check("bad_load_val", 32'(bus.load_val),     32'h47);
    bus.sw_load = 1'b0;
    steps(6);

    // 99 is the largest legal preset; error stays sticky
    bus.sw_preset = 8'h99;
    bus.sw_load   = 1'b1;
    steps(6);
    check("load99_strobe", 32'(bus.cnt_load),   32'h1);
    check("load99_val",    32'(bus.load_val),   32'h99);
    check("err_sticky",    32'(bus.preset_err), 32'h1);
    bus.sw_load = 1'b0;
    steps(6);

    // clear from PAUSE
    bus.btn_clr_n = 1'b0;
    steps(5);
    check("clr_early", 32'(bus.cnt_clr), 32'h0);
    step();
    check("clr_strobe", 32'(bus.cnt_clr),    32'h1);
    check("clr_err",    32'(bus.preset_err), 32'h0);
    check("clr_state",  32'(bus.state),      32'h0);
    step();
    check("clr_width", 32'(bus.cnt_clr), 32'h0);
    bus.btn_clr_n = 1'b1;
    steps(6);

    // clear and run together in RUN: clear wins, run not queued
    press_run(2'b01, "run_again");
    bus.btn_clr_n = 1'b0;
    bus.btn_run_n = 1'b0;
    steps(6);
    check("both_clr",   32'(bus.cnt_clr), 32'h1);
    check("both_state", 32'(bus.state),   32'h0);
    steps(3);
    check("both_no_queue", 32'(bus.state), 32'h0);
    bus.btn_clr_n = 1'b1;
    bus.btn_run_n = 1'b1;
    steps(6);

    // asynchronous reset while cnt_en is high
    press_run(2'b01, "run_last");
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (found == 0) begin
        step();
        if (bus.cnt_en) found = 1;
      end
    end
    check("find_en", 32'(found), 32'h1);
    #3;
    KEY = 1'b0;
    #1;
    check("async_state",    32'(bus.state),      32'h0);
    check("async_cnt_en",   32'(bus.cnt_en),     32'h0);
    check("async_load_val", 32'(bus.load_val),   32'h0);
    check("async_err",      32'(bus.preset_err), 32'h0);
    steps(2);
    #5;
    KEY = 1'b1;
    s_en = n_en; s_clr = n_clr; s_load = n_load;
    steps(10);
    check("post_rst_strobes", 32'((n_en - s_en) + (n_clr - s_clr) + (n_load - s_load)), 32'h0);
    check("post_rst_state",   32'(bus.state), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
